// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the clock frequency monitor.
// Holds the FSM state type, the default divider table and the expected-count helper.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        REPORT
    } state_t;

    localparam int unsigned DEF_DIV0 = 2;
    localparam int unsigned DEF_DIV1 = 4;
    localparam int unsigned DEF_DIV2 = 8;
    localparam int unsigned DEF_DIV3 = 16;

    // Edges expected in one gate window for the reported selection.
    function automatic int unsigned expected_count(
        input logic [1:0]  sel,
        input int unsigned gate,
        input int unsigned d0,
        input int unsigned d1,
        input int unsigned d2,
        input int unsigned d3
    );
        int unsigned div;
        case (sel)
            2'd0:    div = d0;
            2'd1:    div = d1;
            2'd2:    div = d2;
            default: div = d3;
        endcase
        return gate / div;
    endfunction

endpackage

// File: rtl/clk_freq_monitor_if.sv
// Signal bundle between a clock generator (or bench) and the frequency monitor.
// master drives the monitored clock, selection and start; slave is the monitor.
interface clk_freq_monitor_if #(
    parameter int unsigned CNT_W = 7
);
    logic             clk_mon;
    logic [1:0]       which_clk;
    logic             start;
    logic             busy;
    logic             meas_valid;
    logic [CNT_W-1:0] edge_count;
    logic             freq_ok;
    logic             sel_err;

    modport master (
        output clk_mon, which_clk, start,
        input  busy, meas_valid, edge_count, freq_ok, sel_err
    );

    modport slave (
        input  clk_mon, which_clk, start,
        output busy, meas_valid, edge_count, freq_ok, sel_err
    );
endinterface

// File: rtl/clk_mon_sync.sv
// Two-flop synchronizer plus delay flop for the monitored clock.
// o_rise pulses for one clk_in cycle per rising edge seen on i_clk_mon.
module clk_mon_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic i_clk_mon,
    output logic o_rise
);
    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_clk_mon;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/clk_freq_monitor.sv
// Gated edge counter checking a generated clock against the rate implied by which_clk.
// Counts clk_mon rising edges over GATE_CYCLES clk_in cycles and reports pass/fail.
module clk_freq_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 64,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DIV0          = DEF_DIV0,
    parameter int unsigned DIV1          = DEF_DIV1,
    parameter int unsigned DIV2          = DEF_DIV2,
    parameter int unsigned DIV3          = DEF_DIV3,
    parameter int unsigned TOL           = 1,
    localparam int unsigned CNT_W        = $clog2(GATE_CYCLES + 1)
) (
    input  logic               clk_in,
    input  logic               rst,
    clk_freq_monitor_if.slave  mon
);
    localparam int unsigned TMR_W =
        $clog2((GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES);
    localparam logic [TMR_W-1:0]        SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]        GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic signed [CNT_W:0]   TOL_S       = (CNT_W + 1)'(TOL);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [1:0]         r_sel_q;
    logic [CNT_W-1:0]   r_expected;
    logic [CNT_W-1:0]   r_edge_count;
    logic               r_freq_ok;
    logic               r_sel_err;

    logic               w_rise;
    logic               w_sel_chg;
    logic               w_latch;
    logic               w_load;
    logic               w_abort;
    logic [CNT_W-1:0]   w_res_cnt;
    logic signed [CNT_W:0] w_diff;
    logic               w_in_tol;

    clk_mon_sync u_sync (
        .clk_in    (clk_in),
        .rst       (rst),
        .i_clk_mon (mon.clk_mon),
        .o_rise    (w_rise)
    );

    assign w_sel_chg = (mon.which_clk != r_sel_q);
    assign w_cnt_inc = (w_rise && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;

    // A normal window includes the rise seen in its final cycle; an abort reports cnt as it stands.
    assign w_res_cnt = w_abort ? r_cnt : w_cnt_inc;
    assign w_diff    = $signed({1'b0, w_res_cnt}) - $signed({1'b0, r_expected});
    assign w_in_tol  = (w_diff <= TOL_S) && (w_diff >= -TOL_S);

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (mon.start) begin
                    w_state_nxt = SETTLE;
                    w_timer_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_latch     = 1'b1;
                end
            end
            SETTLE: begin
                if (w_sel_chg) begin
                    w_state_nxt = REPORT;
                    w_load      = 1'b1;
                    w_abort     = 1'b1;
                end else if (r_timer == SETTLE_LAST) begin
                    w_state_nxt = MEASURE;
                    w_timer_nxt = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            MEASURE: begin
                if (w_sel_chg) begin
                    w_state_nxt = REPORT;
                    w_load      = 1'b1;
                    w_abort     = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_timer == GATE_LAST) begin
                        w_state_nxt = REPORT;
                        w_load      = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TMR_W'(1);
                    end
                end
            end
            REPORT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_timer      <= '0;
            r_cnt        <= '0;
            r_sel_q      <= '0;
            r_expected   <= '0;
            r_edge_count <= '0;
            r_freq_ok    <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_timer <= w_timer_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_sel_q    <= mon.which_clk;
                r_expected <= CNT_W'(expected_count(mon.which_clk, GATE_CYCLES,
                                                    DIV0, DIV1, DIV2, DIV3));
            end
            if (w_load) begin
                r_edge_count <= w_res_cnt;
                r_freq_ok    <= ~w_abort & w_in_tol;
                r_sel_err    <= w_abort;
            end
        end
    end

    assign mon.busy       = (r_state != IDLE);
    assign mon.meas_valid = (r_state == REPORT);
    assign mon.edge_count = r_edge_count;
    assign mon.freq_ok    = r_freq_ok;
    assign mon.sel_err    = r_sel_err;
endmodule

// File: tb/tb_clk_freq_monitor.sv
// Self-checking bench for clk_freq_monitor: directed and randomized windows
// checked against a history-based model of the clock edges the monitor should see.
module tb_clk_freq_monitor;
    localparam int unsigned GATE   = 64;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned TOLR   = 1;
    localparam int unsigned HN     = 8192;
    localparam int          FULL_LAT = 1 + SETTLE + GATE;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    clk_freq_monitor_if #(.CNT_W(7)) bus ();

    clk_freq_monitor #(
        .GATE_CYCLES   (GATE),
        .SETTLE_CYCLES (SETTLE),
        .DIV0          (2),
        .DIV1          (4),
        .DIV2          (8),
        .DIV3          (16),
        .TOL           (TOLR)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .mon    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitored clock source: 0 = divided clock, 1 = stuck low, 2 = stuck high.
    int mon_mode = 0;
    int mon_div  = 2;
    int mon_skew = 0;
    int free_cnt = 0;

    always @(negedge clk_in) begin
        free_cnt = free_cnt + 1;
        case (mon_mode)
            1:       bus.clk_mon = 1'b0;
            2:       bus.clk_mon = 1'b1;
            default: bus.clk_mon = (((free_cnt + mon_skew) % mon_div) < (mon_div / 2));
        endcase
    end

    // Record clk_mon as sampled at every clk_in rising edge.
    logic hist [HN];
    int   tb_edge = 0;

    always @(posedge clk_in) begin
        hist[tb_edge % HN] = bus.clk_mon;
        tb_edge = tb_edge + 1;
    end

    function automatic int div_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return 2;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 16;
        endcase
    endfunction

    // Rising edges of clk_mon over the edges [first, last], seen through a
    // two-cycle synchronizer delay (rise at edge p reflects samples p-3 -> p-2).
    function automatic int rises_between(input int first, input int last);
        int n = 0;
        for (int p = first; p <= last; p++) begin
            if (hist[(p - 2) % HN] && !hist[(p - 3) % HN]) n++;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One measurement: start at cycle 0, optional extra start at cycle extra_s,
    // optional which_clk change to chg_sel at cycle chg_at.
    task automatic run_meas(input string tag, input logic [1:0] sel,
                            input int extra_s, input int chg_at, input logic [1:0] chg_sel);
        int  e0, cyc, lat, pulses, exp_lat, model_cnt, expct, diff;
        logic got_cnt_ok, busy1, busy_a, busy_b;
        logic [6:0] got_cnt;
        logic got_ok, got_err;
        bit aborted;
        lat = -1; pulses = 0; got_cnt = '0; got_ok = 0; got_err = 0;
        busy1 = 0; busy_a = 1; busy_b = 1; got_cnt_ok = 0;
        aborted = (chg_at >= 1) && (chg_at <= FULL_LAT - 1) && (chg_sel != sel);
        exp_lat = aborted ? chg_at + 1 : FULL_LAT;

        bus.which_clk = sel;
        @(posedge clk_in); #1;
        bus.start = 1'b1;
        e0 = tb_edge - 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_in);
            cyc = tb_edge - 1 - e0;
            if (cyc == 1) busy1 = bus.busy;
            if (bus.meas_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat     = cyc;
                    got_cnt = bus.edge_count;
                    got_ok  = bus.freq_ok;
                    got_err = bus.sel_err;
                end
            end
            if (lat >= 0 && cyc == lat + 1) busy_a = bus.busy;
            if (lat >= 0 && cyc == lat + 2) busy_b = bus.busy;
            bus.start = (cyc == 0) || (extra_s > 0 && cyc == extra_s);
            if (chg_at > 0 && cyc == chg_at) bus.which_clk = chg_sel;
            if (lat >= 0 && cyc >= lat + 3) break;
        end
        bus.start = 1'b0;

        if (aborted)
            model_cnt = rises_between(e0 + SETTLE + 2, e0 + chg_at);
        else
            model_cnt = rises_between(e0 + SETTLE + 2, e0 + SETTLE + GATE + 1);
        if (model_cnt < 0) model_cnt = 0;
        expct = GATE / div_of(sel);
        diff  = model_cnt - expct;
        got_cnt_ok = !aborted && (diff <= int'(TOLR)) && (diff >= -int'(TOLR));

        check({tag, " busy_cycle1"}, busy1, 1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " pulses"}, pulses, 1);
        check({tag, " edge_count"}, got_cnt, model_cnt);
        check({tag, " freq_ok"}, got_ok, got_cnt_ok);
        check({tag, " sel_err"}, got_err, aborted);
        check({tag, " busy_after"}, busy_a, 0);
        check({tag, " busy_after2"}, busy_b, 0);
    endtask

    initial begin
        logic [1:0] rs;
        int mv;
        bus.which_clk = 2'd0;
        bus.start     = 1'b0;
        bus.clk_mon   = 1'b0;

        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        repeat (10) @(negedge clk_in);
        check("reset busy", bus.busy, 0);
        check("reset meas_valid", bus.meas_valid, 0);
        check("reset edge_count", bus.edge_count, 0);
        check("reset freq_ok", bus.freq_ok, 0);
        check("reset sel_err", bus.sel_err, 0);

        mon_mode = 0; mon_div = 2;
        run_meas("div2_sel0", 2'd0, 0, 0, 2'd0);
        mon_div = 16;
        run_meas("div16_sel3", 2'd3, 0, 0, 2'd3);
        mon_div = 8;
        run_meas("div8_sel1", 2'd1, 0, 0, 2'd1);
        mon_mode = 1;
        run_meas("stuck0_dup", 2'd0, 5, 0, 2'd0);
        mon_mode = 2;
        run_meas("stuck1", 2'd2, 0, 0, 2'd2);
        mon_mode = 0; mon_div = 4;
        run_meas("start_in_report", 2'd1, FULL_LAT, 0, 2'd1);
        mon_div = 2;
        run_meas("abort_measure", 2'd0, 0, SETTLE + 1 + 30, 2'd2);
        run_meas("abort_settle", 2'd1, 0, 2, 2'd3);

        // Asynchronous reset in the middle of a window.
        mon_div = 2;
        bus.which_clk = 2'd0;
        @(posedge clk_in); #1; bus.start = 1'b1;
        @(posedge clk_in); #1; bus.start = 1'b0;
        repeat (40) @(negedge clk_in);
        check("pre_rst busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst busy", bus.busy, 0);
        check("rst meas_valid", bus.meas_valid, 0);
        check("rst edge_count", bus.edge_count, 0);
        check("rst freq_ok", bus.freq_ok, 0);
        check("rst sel_err", bus.sel_err, 0);
        mv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (bus.meas_valid) mv++;
        end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            if (bus.meas_valid) mv++;
        end
        check("rst no_pulse", mv, 0);
        run_meas("after_rst", 2'd0, 0, 0, 2'd0);

        for (int t = 0; t < 8; t++) begin
            rs       = 2'($urandom_range(0, 3));
            mon_div  = div_of(2'($urandom_range(0, 3)));
            mon_skew = $urandom_range(0, 15);
            mon_mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
            repeat ($urandom_range(0, 5)) @(negedge clk_in);
            if ($urandom_range(0, 3) == 0)
                run_meas("rand_abort", rs, 0, $urandom_range(1, FULL_LAT - 1), rs + 2'd1);
            else
                run_meas("rand", rs, $urandom_range(0, 1) * $urandom_range(2, 60), 0, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
- Downstream checker for clk_gen_top. Samples the generated clk_out in the clk_in domain and counts its rising edges over a fixed gate window of clk_in cycles.
- Compares the count against the value expected for the reported which_clk selection and flags pass/fail.
- Used as an in-design self-check and as a bench scoreboard for the clock generator.

Parameters:
- GATE_CYCLES, 64, gate window length in clk_in cycles; power of two, ≥ 16.
- SETTLE_CYCLES, 4, clk_in cycles waited after start before counting; flushes the synchronizer.
- DIV0, 2, clk_out period in clk_in cycles when which_clk=0.
- DIV1, 4, clk_out period in clk_in cycles when which_clk=1.
- DIV2, 8, clk_out period in clk_in cycles when which_clk=2.
- DIV3, 16, clk_out period in clk_in cycles when which_clk=3.
- TOL, 1, allowed absolute count error, in edges.

Ports:
- clk_in  input  1  single system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clk_mon  input  1  clk_out from clk_gen_top, treated as data.
- which_clk  input  2  selection reported by clk_gen_top.
- start  input  1  one-cycle request to begin a measurement.
- busy  output  1  high while a measurement is in progress.
- meas_valid  output  1  one-cycle pulse when results update.
- edge_count  output  CNT_W  edges counted in the last window; CNT_W = $clog2(GATE_CYCLES+1).
- freq_ok  output  1  last window was within tolerance of the expected count.
- sel_err  output  1  last window aborted because which_clk changed.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, the counters are 0, and the synchronizer flops are 0. Reset takes effect immediately and asynchronously, including mid-measurement. No result pulse follows a reset.
- Synchronizer: clk_mon passes through 2 flops (s1, s2), then a delay flop s3. rise = s2 & ~s3.
- FSM states: IDLE, SETTLE, MEASURE, REPORT.
- IDLE: on start=1, latch which_clk into sel_q and latch expected = GATE_CYCLES/DIVn. Go to SETTLE with timer=0 and busy=1 from the next cycle.
- SETTLE: timer counts to SETTLE_CYCLES-1, then the FSM goes to MEASURE with timer=0 and cnt=0.
- MEASURE: lasts exactly GATE_CYCLES cycles. cnt increments on each cycle with rise=1 and saturates at all-ones. After the last cycle, go to REPORT.
- which_clk ≠ sel_q in SETTLE or MEASURE: abort immediately to REPORT with an abort flag set.
- REPORT (1 cycle):
  - meas_valid=1.
  - edge_count=cnt.
  - If normal: freq_ok = (|cnt − expected| ≤ TOL) and sel_err=0.
  - If aborted: freq_ok=0 and sel_err=1.
  - Next state is IDLE. busy=0 from the next cycle.
- Outputs edge_count, freq_ok and sel_err hold until the next REPORT.
- Latency: meas_valid is asserted at cycle 1+SETTLE_CYCLES+GATE_CYCLES after the start cycle.
- start while busy is ignored. start in the REPORT cycle is ignored. start in the first IDLE cycle after REPORT is accepted.
- clk_mon stuck (0 or 1) gives cnt=0, hence freq_ok=0.
- The difference is computed at CNT_W+1 bits, signed, to avoid wrap.

Decomposition:
- Package clk_mon_pkg holds:
  - the state enum (IDLE, SETTLE, MEASURE, REPORT);
  - the default DIV constants;
  - a function expected_count(sel) returning GATE_CYCLES/DIVn.
- Sub-module clk_mon_sync contains the 2-flop synchronizer, the delay flop and the rise output. It uses the same clk_in and rst.

Test Plan:
- Reset, then idle 10 cycles → busy=0, meas_valid=0, edge_count=0, freq_ok=0, sel_err=0.
- clk_mon = div-2 of clk_in, which_clk=0, start pulse → meas_valid at cycle 69; edge_count=32±1; freq_ok=1. Repeat with div-16 and which_clk=3 → edge_count=4±1, freq_ok=1.
- which_clk=1 but clk_mon = div-8 → edge_count≈8 vs expected 16 → freq_ok=0, sel_err=0.
- clk_mon held at 0 → edge_count=0, freq_ok=0. Second start pulse 5 cycles after the first → ignored; only one meas_valid is seen.
- which_clk changes 0→2 at cycle 30 of MEASURE → REPORT on the next cycle with sel_err=1, freq_ok=0, busy drops.
- rst asserted mid-MEASURE → outputs go to 0 immediately with no meas_valid. A new start after release → normal result at full latency.
